imm_ctrl_seq: RTL and testbench

- Multi-cycle fetch/decode/execute sequencer for the 8-bit computer.
- Fetches 8-bit instruction bytes over a req/ack memory port and splits each into a 3-bit opcode and a 5-bit immediate.
- Sign-extends the immediate to 8 bits and sequences the accumulator, PC and memory port accordingly.
- Sits between instruction/data memory and the accumulator datapath. It is the sole owner of the memory port.

---
 rtl/imm_ctrl_seq_if.sv | 28 ++
 rtl/imm_ctrl_seq.sv | 163 ++++++++++++++++
 tb/tb_imm_ctrl_seq.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_ctrl_seq_if.sv
// Memory port bundle for imm_ctrl_seq: a req/ack byte bus driven by the sequencer
// (master) and answered by instruction/data memory (slave).
interface imm_ctrl_seq_if;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/imm_ctrl_seq.sv
// Fetch/decode/execute sequencer for the 8-bit computer (3-bit opcode, 5-bit immediate).
// Optional ack watchdog enabled by defining CTRL_WDOG_EN.
module imm_ctrl_seq #(
    parameter logic [7:0] PC_RESET    = 8'h00,
    parameter int         WDOG_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    imm_ctrl_seq_if.master       bus,
    output logic [7:0]           pc,
    output logic [7:0]           acc,
    output logic [7:0]           imm_ext,
    output logic                 halted,
    output logic                 fault
);

    typedef enum logic [1:0] {
        FETCH,
        DECODE,
        MEM,
        HALT
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDI  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_LD   = 3'b011;
    localparam logic [2:0] OP_ST   = 3'b100;
    localparam logic [2:0] OP_BEQZ = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    if (WDOG_CYCLES < 1 || WDOG_CYCLES > 255) begin : g_wdog_range
        $error("imm_ctrl_seq: WDOG_CYCLES must be in 1..255");
    end

    state_t     state;
    logic [7:0] ir;
    logic [2:0] opcode;

    assign opcode  = ir[7:5];
    assign imm_ext = {{3{ir[4]}}, ir[4:0]};

    // Bus outputs decode from the registered state; reset forces them idle.
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 8'h00;
        bus.mem_wdata = 8'h00;
        if (!rst) begin
            case (state)
                FETCH: begin
                    bus.mem_req  = 1'b1;
                    bus.mem_addr = pc;
                end
                MEM: begin
                    bus.mem_req   = 1'b1;
                    bus.mem_we    = (opcode == OP_ST);
                    bus.mem_addr  = {3'b000, ir[4:0]};
                    bus.mem_wdata = acc;
                end
                default: ;
            endcase
        end
    end

`ifdef CTRL_WDOG_EN
    logic [7:0] wait_cnt;
    logic       fault_r;
    logic       wdog_trip;

    assign wdog_trip = (wait_cnt == 8'(WDOG_CYCLES - 1));
    assign fault     = fault_r;
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FETCH;
            pc     <= PC_RESET;
            acc    <= 8'h00;
            ir     <= 8'h00;
            halted <= 1'b0;
`ifdef CTRL_WDOG_EN
            wait_cnt <= 8'h00;
            fault_r  <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    if (bus.mem_ack) begin
                        ir    <= bus.mem_rdata;
                        pc    <= pc + 8'd1;
                        state <= DECODE;
`ifdef CTRL_WDOG_EN
                        wait_cnt <= 8'h00;
                    end else if (wdog_trip) begin
                        fault_r <= 1'b1;
                        halted  <= 1'b1;
                        state   <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
`endif
                    end
                end
                DECODE: begin
`ifdef CTRL_WDOG_EN
                    wait_cnt <= 8'h00;
`endif
                    // Branch targets are relative to the already-incremented pc.
                    case (opcode)
                        OP_NOP:  state <= FETCH;
                        OP_LDI: begin
                            acc   <= imm_ext;
                            state <= FETCH;
                        end
                        OP_ADDI: begin
                            acc   <= acc + imm_ext;
                            state <= FETCH;
                        end
                        OP_LD, OP_ST: state <= MEM;
                        OP_BEQZ: begin
                            if (acc == 8'h00) begin
                                pc <= pc + imm_ext;
                            end
                            state <= FETCH;
                        end
                        OP_JMP: begin
                            pc    <= pc + imm_ext;
                            state <= FETCH;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end
                        default: state <= FETCH;
                    endcase
                end
                MEM: begin
                    if (bus.mem_ack) begin
                        if (opcode == OP_LD) begin
                            acc <= bus.mem_rdata;
                        end
                        state <= FETCH;
`ifdef CTRL_WDOG_EN
                        wait_cnt <= 8'h00;
                    end else if (wdog_trip) begin
                        fault_r <= 1'b1;
                        halted  <= 1'b1;
                        state   <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
`endif
                    end
                end
                HALT: state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_ctrl_seq.sv
// Self-checking bench for imm_ctrl_seq: an ISA-level model pushes expected pc/acc/imm
// per instruction into a scoreboard, popped once the DUT has had time to retire it.
module tb_imm_ctrl_seq;

    typedef struct {
        string      tag;
        logic [7:0] pc;
        logic [7:0] acc;
        logic [7:0] imm;
        logic       halted;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] pc;
    logic [7:0] acc;
    logic [7:0] imm_ext;
    logic       halted;
    logic       fault;

    imm_ctrl_seq_if bus ();

    imm_ctrl_seq #(
        .PC_RESET    (8'h00),
        .WDOG_CYCLES (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .pc      (pc),
        .acc     (acc),
        .imm_ext (imm_ext),
        .halted  (halted),
        .fault   (fault)
    );

    int         checks   = 0;
    int         failures = 0;
    exp_t       sb[$];

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic [7:0] m_pc;
    logic [7:0] m_acc;
    logic       m_halted;

    int         ack_delay = 0;
    int         ack_wait  = 0;
    logic       ack_en    = 1'b1;
    logic       stray_ack = 1'b0;
    logic [7:0] st_addr_seen = 8'h00;
    logic [7:0] st_data_seen = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory slave: responds on the falling edge so the DUT samples a settled ack.
    always @(negedge clk) begin
        if (stray_ack) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 8'h77;
            ack_wait      = 0;
        end else if (ack_en && bus.mem_req) begin
            if (ack_wait >= ack_delay) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem[bus.mem_addr];
                if (bus.mem_we) begin
                    st_addr_seen = bus.mem_addr;
                    st_data_seen = bus.mem_wdata;
                end
                ack_wait = 0;
            end else begin
                bus.mem_ack = 1'b0;
                ack_wait++;
            end
        end else begin
            bus.mem_ack = 1'b0;
            ack_wait    = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] addr, input logic [7:0] data);
        mem[addr]     = data;
        ref_mem[addr] = data;
    endtask

    task automatic modelReset();
        m_pc     = 8'h00;
        m_acc    = 8'h00;
        m_halted = 1'b0;
        sb.delete();
    endtask

    // Places the instruction at the model pc and predicts its architectural effect.
    task automatic applyStimulus(input string tag, input logic [7:0] instr);
        logic [7:0] imm;
        logic [7:0] npc;
        exp_t       e;
        imm = {{3{instr[4]}}, instr[4:0]};
        npc = m_pc + 8'd1;
        poke(m_pc, instr);
        case (instr[7:5])
            3'b001: m_acc = imm;
            3'b010: m_acc = m_acc + imm;
            3'b011: m_acc = ref_mem[{3'b000, instr[4:0]}];
            3'b100: ref_mem[{3'b000, instr[4:0]}] = m_acc;
            3'b101: if (m_acc == 8'h00) npc = npc + imm;
            3'b110: npc = npc + imm;
            3'b111: m_halted = 1'b1;
            default: ;
        endcase
        m_pc = npc;
        e.tag    = tag;
        e.pc     = m_pc;
        e.acc    = m_acc;
        e.imm    = imm;
        e.halted = m_halted;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL sb_empty observed=0 expected=1 entries");
        end else begin
            e = sb.pop_front();
            checkVal({e.tag, "_pc"}, pc, e.pc);
            checkVal({e.tag, "_acc"}, acc, e.acc);
            checkVal({e.tag, "_imm"}, imm_ext, e.imm);
            checkVal({e.tag, "_halted"}, {7'b0, halted}, {7'b0, e.halted});
        end
    endtask

    task automatic execute(input string tag, input logic [7:0] instr);
        int lat;
        applyStimulus(tag, instr);
        lat = (instr[7:5] == 3'b011 || instr[7:5] == 3'b100) ? 3 : 2;
        repeat (lat) tick();
        checkOutput();
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 256; i++) poke(8'(i), 8'h00);
        modelReset();

        tick();
        checkVal("rst_req", {7'b0, bus.mem_req}, 8'h00);
        checkVal("rst_pc", pc, 8'h00);
        checkVal("rst_acc", acc, 8'h00);
        checkVal("rst_imm", imm_ext, 8'h00);
        checkVal("rst_halted", {7'b0, halted}, 8'h00);
        checkVal("rst_fault", {7'b0, fault}, 8'h00);
        tick();

        applyStimulus("ldi_m5", 8'h3B);
        rst = 1'b0;
        #1;
        checkVal("first_req", {7'b0, bus.mem_req}, 8'h01);
        checkVal("first_addr", bus.mem_addr, 8'h00);
        repeat (2) tick();
        checkOutput();

        execute("addi_p7", 8'h47);
        execute("addi_m2", 8'h5E);
        execute("jmp_p1", 8'hC1);
        execute("beqz_taken", 8'hBD);
        execute("ldi_1", 8'h21);
        execute("jmp_0", 8'hC0);
        execute("beqz_not", 8'hBD);
        execute("jmp_to_ff", 8'hD8);
        execute("jmp_m1_ff", 8'hDF);
        execute("nop_wrap", 8'h00);
        execute("jmp_m1_00", 8'hDF);

        poke(8'h10, 8'hA5);
        execute("ld_a5", 8'h70);

        // Store with two wait states on every transaction: req held three cycles.
        applyStimulus("st_1f", 8'h9F);
        ack_delay = 2;
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            checkVal("st_req", {7'b0, bus.mem_req}, 8'h01);
            checkVal("st_we", {7'b0, bus.mem_we}, 8'h01);
            checkVal("st_addr", bus.mem_addr, 8'h1F);
            checkVal("st_wdata", bus.mem_wdata, 8'hA5);
            tick();
        end
        checkVal("st_after_we", {7'b0, bus.mem_we}, 8'h00);
        checkVal("st_after_addr", bus.mem_addr, m_pc);
        checkOutput();
        checkVal("st_bus_data", st_data_seen, 8'hA5);
        mem[st_addr_seen] = st_data_seen;
        ack_delay = 0;

        execute("ldi_0", 8'h20);
        execute("ld_1f", 8'h7F);

        // Reset while an LD waits for its data ack.
        poke(m_pc, 8'h70);
        repeat (2) tick();
        checkVal("ldw_addr", bus.mem_addr, 8'h10);
        ack_en = 1'b0;
        tick();
        rst       = 1'b1;
        stray_ack = 1'b1;
        tick();
        checkVal("mid_rst_req", {7'b0, bus.mem_req}, 8'h00);
        checkVal("mid_rst_pc", pc, 8'h00);
        checkVal("mid_rst_acc", acc, 8'h00);
        rst       = 1'b0;
        stray_ack = 1'b0;
        #1;
        checkVal("rel_req", {7'b0, bus.mem_req}, 8'h01);
        checkVal("rel_addr", bus.mem_addr, 8'h00);
        tick();
        checkVal("no_stale_pc", pc, 8'h00);
        modelReset();
        ack_en = 1'b1;
        execute("ldi_p10", 8'h2A);

        execute("halt", 8'hFF);
        stray_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checkVal("halt_req", {7'b0, bus.mem_req}, 8'h00);
        end
        stray_ack = 1'b0;
        checkVal("halt_pc_hold", pc, m_pc);
        checkVal("halt_acc_hold", acc, m_acc);
        checkVal("halt_fault", {7'b0, fault}, 8'h00);

`ifdef CTRL_WDOG_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelReset();
        ack_en = 1'b0;
        repeat (3) tick();
        checkVal("wdog_pre_fault", {7'b0, fault}, 8'h00);
        tick();
        checkVal("wdog_fault", {7'b0, fault}, 8'h01);
        checkVal("wdog_halted", {7'b0, halted}, 8'h01);
        checkVal("wdog_req", {7'b0, bus.mem_req}, 8'h00);
        checkVal("wdog_pc", pc, 8'h00);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        poke(8'h00, 8'h3B);
        ack_en    = 1'b1;
        ack_delay = 3;
        repeat (4) tick();
        checkVal("wdog_late_ack_fault", {7'b0, fault}, 8'h00);
        checkVal("wdog_late_ack_pc", pc, 8'h01);
        tick();
        checkVal("wdog_late_ack_acc", acc, 8'hFB);
        ack_delay = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
